// File: rtl/aemb2_xsl_pkg.sv
// Shared definitions for the AEMB2 XSL queue: opcode decode, immediate field
// positions and bus-engine state encoding.
package aemb2_xsl_pkg;

  localparam int IMM_PUT = 15;
  localparam int IMM_NB  = 14;
  localparam int IMM_TAG = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } xsl_state_e;

  // GET/PUT share one major opcode; direction comes from the immediate.
  function automatic logic is_xsl_op(input logic [5:0] opc);
    return !opc[5] && opc[4] && opc[3] && opc[1];
  endfunction

endpackage

// File: rtl/aemb2_xsl_fifo.sv
// Small synchronous FIFO holding posted XSL writes; head entry is visible
// combinationally so the bus engine can launch a cycle straight from it.
module aemb2_xsl_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                   gclk,
  input  logic                   grst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge gclk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge gclk) begin
    if (grst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/aemb2_xsl_queue.sv
// Multi-channel XSL bus interface: posted PUT queue with a one-entry stall
// register, ordered GETs, non-blocking carry result and an autonomous bus engine.
module aemb2_xsl_queue
  import aemb2_xsl_pkg::*;
#(
  parameter int AEMB_XWB = 3,
  parameter int XSL_DEP  = 4,
  parameter int XSL_TMO  = 15
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                dena,
  input  logic                gpha,
  input  logic [5:0]          opc_of,
  input  logic [15:0]         imm_of,
  input  logic [31:0]         opa_of,
  output logic [AEMB_XWB-3:0] xwb_adr_o,
  output logic [31:0]         xwb_dat_o,
  output logic [3:0]          xwb_sel_o,
  output logic                xwb_tag_o,
  output logic                xwb_wre_o,
  output logic                xwb_stb_o,
  output logic                xwb_cyc_o,
  input  logic [31:0]         xwb_dat_i,
  input  logic                xwb_ack_i,
  output logic                xwb_fb,
  output logic [31:0]         xwb_mx,
  output logic                xwb_c
);

  localparam int CW = AEMB_XWB - 2;
  localparam int QW = CW + 1 + 32;
  localparam logic [7:0] TMO_LAST = 8'(XSL_TMO - 1);

  xsl_state_e state_reg, state_next;
  logic          stb_reg, stb_next;
  logic          wre_reg, wre_next;
  logic          tag_reg, tag_next;
  logic [CW-1:0] adr_reg, adr_next;
  logic [31:0]   dat_reg, dat_next;
  logic [31:0]   mx_reg, mx_next;
  logic          c_reg, c_next;
  logic          get_pend_reg, get_pend_next;
  logic          get_nb_reg, get_nb_next;
  logic          get_tag_reg, get_tag_next;
  logic [CW-1:0] get_chan_reg, get_chan_next;
  logic          hold_valid_reg, hold_valid_next;
  logic [QW-1:0] hold_entry_reg, hold_entry_next;
  logic [7:0]    tmo_reg, tmo_next;

  logic                     op_ok;
  logic                     op_put;
  logic                     op_nb;
  logic [QW-1:0]            op_entry;
  logic                     q_push;
  logic                     q_pop;
  logic [QW-1:0]            q_din;
  logic [QW-1:0]            q_dout;
  logic                     q_full;
  logic                     q_empty;
  logic [$clog2(XSL_DEP):0] q_count;
  logic                     unused_bits;

  assign xwb_fb   = !get_pend_reg && !hold_valid_reg;
  assign op_ok    = dena && xwb_fb && is_xsl_op(opc_of);
  assign op_put   = imm_of[IMM_PUT];
  assign op_nb    = imm_of[IMM_NB];
  assign op_entry = {imm_of[CW-1:0], imm_of[IMM_TAG], opa_of};

  // The hold register only fills while the pipeline is stalled, so it never
  // competes with a newly accepted PUT for the push port.
  assign q_push = !q_full && (hold_valid_reg || (op_ok && op_put));
  assign q_din  = hold_valid_reg ? hold_entry_reg : op_entry;
  assign q_pop  = (state_reg == ST_WR) && xwb_ack_i;

  aemb2_xsl_fifo #(
    .WIDTH (QW),
    .DEPTH (XSL_DEP)
  ) u_fifo (
    .gclk  (gclk),
    .grst  (grst),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    state_next      = state_reg;
    stb_next        = stb_reg;
    wre_next        = wre_reg;
    tag_next        = tag_reg;
    adr_next        = adr_reg;
    dat_next        = dat_reg;
    mx_next         = mx_reg;
    c_next          = c_reg;
    get_pend_next   = get_pend_reg;
    get_nb_next     = get_nb_reg;
    get_tag_next    = get_tag_reg;
    get_chan_next   = get_chan_reg;
    hold_valid_next = hold_valid_reg;
    hold_entry_next = hold_entry_reg;
    tmo_next        = tmo_reg;

    if (op_ok) begin
      if (op_put) begin
        if (!q_full) begin
          c_next = 1'b0;
        end else if (!op_nb) begin
          hold_valid_next = 1'b1;
          hold_entry_next = op_entry;
          c_next          = 1'b0;
        end else begin
          c_next = 1'b1;
        end
      end else begin
        get_pend_next = 1'b1;
        get_nb_next   = op_nb;
        get_tag_next  = imm_of[IMM_TAG];
        get_chan_next = imm_of[CW-1:0];
      end
    end

    if (hold_valid_reg && !q_full) hold_valid_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Posted writes drain before any read so GETs observe earlier PUTs.
        if (!q_empty) begin
          state_next                     = ST_WR;
          stb_next                       = 1'b1;
          wre_next                       = 1'b1;
          {adr_next, tag_next, dat_next} = q_dout;
        end else if (get_pend_reg && !hold_valid_reg) begin
          state_next = ST_RD;
          stb_next   = 1'b1;
          wre_next   = 1'b0;
          adr_next   = get_chan_reg;
          tag_next   = get_tag_reg;
          tmo_next   = 8'd0;
        end
      end
      ST_WR: begin
        if (xwb_ack_i) begin
          state_next = ST_IDLE;
          stb_next   = 1'b0;
        end
      end
      ST_RD: begin
        if (xwb_ack_i) begin
          state_next    = ST_IDLE;
          stb_next      = 1'b0;
          mx_next       = xwb_dat_i;
          c_next        = 1'b0;
          get_pend_next = 1'b0;
          tmo_next      = 8'd0;
        end else if (get_nb_reg && (tmo_reg == TMO_LAST)) begin
          state_next    = ST_IDLE;
          stb_next      = 1'b0;
          mx_next       = 32'd0;
          c_next        = 1'b1;
          get_pend_next = 1'b0;
          tmo_next      = 8'd0;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        stb_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_reg      <= ST_IDLE;
      stb_reg        <= 1'b0;
      wre_reg        <= 1'b0;
      tag_reg        <= 1'b0;
      adr_reg        <= '0;
      dat_reg        <= 32'd0;
      mx_reg         <= 32'd0;
      c_reg          <= 1'b0;
      get_pend_reg   <= 1'b0;
      get_nb_reg     <= 1'b0;
      get_tag_reg    <= 1'b0;
      get_chan_reg   <= '0;
      hold_valid_reg <= 1'b0;
      hold_entry_reg <= '0;
      tmo_reg        <= 8'd0;
    end else begin
      state_reg      <= state_next;
      stb_reg        <= stb_next;
      wre_reg        <= wre_next;
      tag_reg        <= tag_next;
      adr_reg        <= adr_next;
      dat_reg        <= dat_next;
      mx_reg         <= mx_next;
      c_reg          <= c_next;
      get_pend_reg   <= get_pend_next;
      get_nb_reg     <= get_nb_next;
      get_tag_reg    <= get_tag_next;
      get_chan_reg   <= get_chan_next;
      hold_valid_reg <= hold_valid_next;
      hold_entry_reg <= hold_entry_next;
      tmo_reg        <= tmo_next;
    end
  end

  assign xwb_adr_o = adr_reg;
  assign xwb_dat_o = dat_reg;
  assign xwb_sel_o = 4'hF;
  assign xwb_tag_o = tag_reg;
  assign xwb_wre_o = wre_reg;
  assign xwb_stb_o = stb_reg;
  assign xwb_cyc_o = stb_reg;
  assign xwb_mx    = mx_reg;
  assign xwb_c     = c_reg;

  assign unused_bits = &{1'b0, gpha, imm_of[12:CW], q_count};

endmodule

// File: tb/tb_aemb2_xsl_queue.sv
// Directed bench for aemb2_xsl_queue: posted writes, stall/drop at full queue,
// ordered GET, nGET timeout, blocking GET and mid-operation reset.
module tb_aemb2_xsl_queue;

  logic        gclk = 1'b0;
  logic        grst = 1'b1;
  logic        dena = 1'b0;
  logic        gpha = 1'b0;
  logic [5:0]  opc_of = 6'd0;
  logic [15:0] imm_of = 16'd0;
  logic [31:0] opa_of = 32'd0;
  logic [1:0]  xwb_adr_o;
  logic [31:0] xwb_dat_o;
  logic [3:0]  xwb_sel_o;
  logic        xwb_tag_o;
  logic        xwb_wre_o;
  logic        xwb_stb_o;
  logic        xwb_cyc_o;
  logic [31:0] xwb_dat_i = 32'd0;
  logic        xwb_ack_i = 1'b0;
  logic        xwb_fb;
  logic [31:0] xwb_mx;
  logic        xwb_c;

  int n_vec = 0;
  int n_err = 0;
  int wr_done = 0;

  aemb2_xsl_queue #(
    .AEMB_XWB (4),
    .XSL_DEP  (4),
    .XSL_TMO  (15)
  ) dut (
    .gclk      (gclk),
    .grst      (grst),
    .dena      (dena),
    .gpha      (gpha),
    .opc_of    (opc_of),
    .imm_of    (imm_of),
    .opa_of    (opa_of),
    .xwb_adr_o (xwb_adr_o),
    .xwb_dat_o (xwb_dat_o),
    .xwb_sel_o (xwb_sel_o),
    .xwb_tag_o (xwb_tag_o),
    .xwb_wre_o (xwb_wre_o),
    .xwb_stb_o (xwb_stb_o),
    .xwb_cyc_o (xwb_cyc_o),
    .xwb_dat_i (xwb_dat_i),
    .xwb_ack_i (xwb_ack_i),
    .xwb_fb    (xwb_fb),
    .xwb_mx    (xwb_mx),
    .xwb_c     (xwb_c)
  );

  always #5 gclk = ~gclk;

  always @(posedge gclk) begin
    if (xwb_stb_o && xwb_ack_i && xwb_wre_o) wr_done <= wr_done + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one GET/PUT for a single accept edge; returns at the next negedge.
  task automatic do_op(input logic put, input logic nb, input logic tag,
                       input logic [1:0] ch, input logic [31:0] d);
    dena   = 1'b1;
    opc_of = 6'h1B;
    imm_of = {put, nb, tag, 11'd0, ch};
    opa_of = d;
    @(negedge gclk);
    dena   = 1'b0;
    $display("op %s%s ch=%0d tag=%0d dat=%h", nb ? "n" : "", put ? "PUT" : "GET", ch, tag, d);
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (!xwb_stb_o && n < 50) begin
      @(negedge gclk);
      n++;
    end
    chk(tag, {31'd0, xwb_stb_o}, 32'd1);
  endtask

  task automatic ack_write(input logic [1:0] ch, input logic [31:0] d);
    wait_stb("wr_stb");
    chk("wr_wre", {31'd0, xwb_wre_o}, 32'd1);
    chk("wr_adr", {30'd0, xwb_adr_o}, {30'd0, ch});
    chk("wr_dat", xwb_dat_o, d);
    xwb_ack_i = 1'b1;
    @(negedge gclk);
    xwb_ack_i = 1'b0;
    chk("wr_stb_drop", {31'd0, xwb_stb_o}, 32'd0);
    $display("write ack ch=%0d dat=%h", ch, d);
  endtask

  initial begin
    int base;
    int cnt;

    // Reset values
    repeat (3) @(negedge gclk);
    grst = 1'b0;
    chk("rst_stb", {31'd0, xwb_stb_o}, 32'd0);
    chk("rst_cyc", {31'd0, xwb_cyc_o}, 32'd0);
    chk("rst_fb", {31'd0, xwb_fb}, 32'd1);
    chk("rst_mx", xwb_mx, 32'd0);
    chk("rst_c", {31'd0, xwb_c}, 32'd0);
    chk("rst_sel", {28'd0, xwb_sel_o}, 32'hF);

    // Single PUT ch1
    do_op(1'b1, 1'b0, 1'b0, 2'd1, 32'hDEADBEEF);
    chk("p1_fb", {31'd0, xwb_fb}, 32'd1);
    chk("p1_stb_lat", {31'd0, xwb_stb_o}, 32'd0);
    @(negedge gclk);
    chk("p1_stb", {31'd0, xwb_stb_o}, 32'd1);
    chk("p1_tag", {31'd0, xwb_tag_o}, 32'd0);
    ack_write(2'd1, 32'hDEADBEEF);
    chk("p1_fb2", {31'd0, xwb_fb}, 32'd1);
    chk("p1_c", {31'd0, xwb_c}, 32'd0);
    chk("p1_writes", wr_done, 32'd1);

    // Five blocking PUTs into a depth-4 queue with ack held low
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 1'b0, 2'(i), 32'h1000_0001 + i);
    chk("stall_fb", {31'd0, xwb_fb}, 32'd0);
    chk("stall_c", {31'd0, xwb_c}, 32'd0);
    chk("stall_dat", xwb_dat_o, 32'h1000_0001);
    xwb_ack_i = 1'b1;
    @(negedge gclk);
    xwb_ack_i = 1'b0;
    chk("hold_fb", {31'd0, xwb_fb}, 32'd0);
    chk("hold_stb_gap", {31'd0, xwb_stb_o}, 32'd0);
    @(negedge gclk);
    chk("hold_release_fb", {31'd0, xwb_fb}, 32'd1);
    for (int i = 1; i < 5; i++) ack_write(2'(i), 32'h1000_0001 + i);
    repeat (3) @(negedge gclk);
    chk("stall_idle", {31'd0, xwb_stb_o}, 32'd0);

    // Same, fifth op non-blocking: dropped with carry
    base = wr_done;
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 1'b0, 2'(i), 32'h2000_0000 + i);
    do_op(1'b1, 1'b1, 1'b0, 2'd0, 32'h2000_0004);
    chk("nput_fb", {31'd0, xwb_fb}, 32'd1);
    chk("nput_c", {31'd0, xwb_c}, 32'd1);
    for (int i = 0; i < 4; i++) ack_write(2'(i), 32'h2000_0000 + i);
    repeat (5) @(negedge gclk);
    chk("nput_idle", {31'd0, xwb_stb_o}, 32'd0);
    chk("nput_writes", wr_done - base, 32'd4);

    // PUT ch2 then GET ch2: write must finish before read strobes
    base = wr_done;
    do_op(1'b1, 1'b0, 1'b0, 2'd2, 32'hAAAA5555);
    chk("pg_c", {31'd0, xwb_c}, 32'd0);
    do_op(1'b0, 1'b0, 1'b0, 2'd2, 32'd0);
    chk("pg_fb", {31'd0, xwb_fb}, 32'd0);
    ack_write(2'd2, 32'hAAAA5555);
    wait_stb("rd_stb");
    chk("rd_order", wr_done - base, 32'd1);
    chk("rd_wre", {31'd0, xwb_wre_o}, 32'd0);
    chk("rd_adr", {30'd0, xwb_adr_o}, 32'd2);
    xwb_dat_i = 32'h12345678;
    xwb_ack_i = 1'b1;
    @(negedge gclk);
    xwb_ack_i = 1'b0;
    $display("read ack ch=2 dat=%h", xwb_dat_i);
    chk("rd_mx", xwb_mx, 32'h12345678);
    chk("rd_c", {31'd0, xwb_c}, 32'd0);
    chk("rd_fb", {31'd0, xwb_fb}, 32'd1);
    chk("rd_stb_drop", {31'd0, xwb_stb_o}, 32'd0);

    // nGET with no ack: 15 strobe cycles then abort
    xwb_dat_i = 32'h5A5A5A5A;
    do_op(1'b0, 1'b1, 1'b0, 2'd1, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (xwb_stb_o) cnt++;
      @(negedge gclk);
    end
    chk("tmo_cycles", cnt, 32'd15);
    chk("tmo_mx", xwb_mx, 32'd0);
    chk("tmo_c", {31'd0, xwb_c}, 32'd1);
    chk("tmo_fb", {31'd0, xwb_fb}, 32'd1);

    // Blocking GET outlives the timeout, then completes and clears carry
    do_op(1'b0, 1'b0, 1'b1, 2'd3, 32'd0);
    repeat (30) @(negedge gclk);
    chk("bget_stb", {31'd0, xwb_stb_o}, 32'd1);
    chk("bget_adr", {30'd0, xwb_adr_o}, 32'd3);
    chk("bget_tag", {31'd0, xwb_tag_o}, 32'd1);
    chk("bget_fb", {31'd0, xwb_fb}, 32'd0);
    xwb_dat_i = 32'hCAFEF00D;
    xwb_ack_i = 1'b1;
    @(negedge gclk);
    xwb_ack_i = 1'b0;
    $display("read ack ch=3 dat=%h", xwb_dat_i);
    chk("bget_mx", xwb_mx, 32'hCAFEF00D);
    chk("bget_c", {31'd0, xwb_c}, 32'd0);
    chk("bget_fb2", {31'd0, xwb_fb}, 32'd1);

    // Reset during a blocking GET with two queued PUTs
    base = wr_done;
    do_op(1'b1, 1'b0, 1'b1, 2'd1, 32'h77777777);
    do_op(1'b1, 1'b0, 1'b0, 2'd2, 32'h88888888);
    do_op(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    chk("pre_rst_stb", {31'd0, xwb_stb_o}, 32'd1);
    chk("pre_rst_tag", {31'd0, xwb_tag_o}, 32'd1);
    grst = 1'b1;
    @(negedge gclk);
    grst = 1'b0;
    chk("mr_stb", {31'd0, xwb_stb_o}, 32'd0);
    chk("mr_cyc", {31'd0, xwb_cyc_o}, 32'd0);
    chk("mr_adr", {30'd0, xwb_adr_o}, 32'd0);
    chk("mr_dat", xwb_dat_o, 32'd0);
    chk("mr_tag", {31'd0, xwb_tag_o}, 32'd0);
    chk("mr_wre", {31'd0, xwb_wre_o}, 32'd0);
    chk("mr_mx", xwb_mx, 32'd0);
    chk("mr_c", {31'd0, xwb_c}, 32'd0);
    chk("mr_fb", {31'd0, xwb_fb}, 32'd1);
    xwb_ack_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge gclk);
      if (xwb_stb_o) cnt++;
    end
    xwb_ack_i = 1'b0;
    chk("mr_no_cycles", cnt, 32'd0);
    chk("mr_no_writes", wr_done - base, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
